// File: rtl/weight_ser_out.sv
// weight_ser_out: latches the trained weight vector on start and shifts each word
// off-chip UART-style (start bit, LENGTH data bits LSB first, stop bit).
module weight_ser_out #(
  parameter int LENGTH        = 16,
  parameter int MAX_FEATURES  = 15,
  parameter int WEIGHTS_WIDTH = LENGTH * (MAX_FEATURES + 1),
  parameter int CLKS_PER_BIT  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [3:0]               feat,
  input  logic [WEIGHTS_WIDTH-1:0] weights,
  output logic                     ser_out,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               word_idx
);

  localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW     = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int NWORDS = MAX_FEATURES + 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    STOP_BIT  = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CW-1:0]     clk_cnt_r;
  logic [CW-1:0]     clk_cnt_s;
  logic [BW-1:0]     bit_idx_r;
  logic [BW-1:0]     bit_idx_s;
  logic [3:0]        word_idx_r;
  logic [3:0]        word_idx_s;
  logic [3:0]        feat_r;
  logic [LENGTH-1:0] words_r [0:NWORDS-1];
  logic              accept_s;
  logic              wrap_s;
  logic              cur_bit_s;
  logic              ser_out_s;
  logic              busy_s;
  logic              done_s;
  logic              ser_out_r;
  logic              busy_r;
  logic              done_r;

  assign accept_s = (state_r == IDLE) && start;
  assign wrap_s   = (clk_cnt_r == CLK_LAST);

  // Snapshot of the weight vector and feature count taken when a transfer is accepted
  always_ff @(posedge CLK) begin
    if (RST) begin
      feat_r <= 4'd0;
      for (int k = 0; k < NWORDS; k++) begin
        words_r[k] <= {LENGTH{1'b0}};
      end
    end else if (accept_s) begin
      feat_r <= feat;
      for (int k = 0; k < NWORDS; k++) begin
        words_r[k] <= weights[k*LENGTH +: LENGTH];
      end
    end
  end

  // State and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      clk_cnt_r  <= {CW{1'b0}};
      bit_idx_r  <= {BW{1'b0}};
      word_idx_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      clk_cnt_r  <= clk_cnt_s;
      bit_idx_r  <= bit_idx_s;
      word_idx_r <= word_idx_s;
    end
  end

  // Next-state and counter advance; every bit lasts CLKS_PER_BIT cycles
  always_comb begin
    state_s    = state_r;
    clk_cnt_s  = wrap_s ? {CW{1'b0}} : (clk_cnt_r + CW'(1));
    bit_idx_s  = bit_idx_r;
    word_idx_s = word_idx_r;
    case (state_r)
      IDLE: begin
        clk_cnt_s = {CW{1'b0}};
        bit_idx_s = {BW{1'b0}};
        if (start) begin
          state_s    = START_BIT;
          word_idx_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START_BIT: begin
        if (wrap_s) begin
          state_s   = DATA;
          bit_idx_s = {BW{1'b0}};
        end else begin
          state_s = START_BIT;
        end
      end
      DATA: begin
        if (wrap_s && (bit_idx_r == BIT_LAST)) begin
          state_s   = STOP_BIT;
          bit_idx_s = {BW{1'b0}};
        end else if (wrap_s) begin
          bit_idx_s = bit_idx_r + BW'(1);
        end else begin
          state_s = DATA;
        end
      end
      STOP_BIT: begin
        // Back-to-back frames: next word starts straight after this stop bit
        if (wrap_s && (word_idx_r < feat_r)) begin
          state_s    = START_BIT;
          word_idx_s = word_idx_r + 4'd1;
        end else if (wrap_s) begin
          state_s = FINISH;
        end else begin
          state_s = STOP_BIT;
        end
      end
      FINISH: begin
        state_s   = IDLE;
        clk_cnt_s = {CW{1'b0}};
      end
      default: begin
        state_s    = IDLE;
        clk_cnt_s  = {CW{1'b0}};
        bit_idx_s  = {BW{1'b0}};
        word_idx_s = 4'd0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so they can be registered
  always_comb begin
    cur_bit_s = words_r[word_idx_s][bit_idx_s];
    ser_out_s = 1'b1;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_s)
      IDLE: begin
        ser_out_s = 1'b1;
        busy_s    = 1'b0;
        done_s    = 1'b0;
      end
      START_BIT: begin
        ser_out_s = 1'b0;
        busy_s    = 1'b1;
        done_s    = 1'b0;
      end
      DATA: begin
        ser_out_s = cur_bit_s;
        busy_s    = 1'b1;
        done_s    = 1'b0;
      end
      STOP_BIT: begin
        ser_out_s = 1'b1;
        busy_s    = 1'b1;
        done_s    = 1'b0;
      end
      FINISH: begin
        ser_out_s = 1'b1;
        busy_s    = 1'b0;
        done_s    = 1'b1;
      end
      default: begin
        ser_out_s = 1'b1;
        busy_s    = 1'b0;
        done_s    = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ser_out_r <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      ser_out_r <= ser_out_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign ser_out  = ser_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign word_idx = word_idx_r;

endmodule

// File: tb/tb_weight_ser_out.sv
// Bench for weight_ser_out: a queue-based frame model per instance checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_weight_ser_out;

  localparam int LEN = 16;
  localparam int WW  = 256;

  typedef struct packed {
    logic       ser;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } ent_t;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          start0 = 1'b0;
  logic          start1 = 1'b0;
  logic [3:0]    feat0 = 4'd0;
  logic [3:0]    feat1 = 4'd0;
  logic [WW-1:0] weights0 = {WW{1'b0}};
  logic [WW-1:0] weights1 = {WW{1'b0}};
  logic          s0, b0, d0, s1, b1, d1;
  logic [3:0]    i0, i1;

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  ent_t q0[$];
  ent_t q1[$];
  ent_t e0 = 7'b100_0000;
  ent_t e1 = 7'b100_0000;

  logic       ser_log  [1:1300];
  logic       busy_log [1:1300];
  logic       done_log [1:1300];
  logic [3:0] idx_log  [1:1300];

  always #5 clk = ~clk;

  weight_ser_out #(.LENGTH(16), .MAX_FEATURES(15), .CLKS_PER_BIT(4)) u_dut0 (
    .CLK(clk), .RST(RST), .start(start0), .feat(feat0), .weights(weights0),
    .ser_out(s0), .busy(b0), .done(d0), .word_idx(i0));

  weight_ser_out #(.LENGTH(16), .MAX_FEATURES(15), .CLKS_PER_BIT(1)) u_dut1 (
    .CLK(clk), .RST(RST), .start(start1), .feat(feat1), .weights(weights1),
    .ser_out(s1), .busy(b1), .done(d1), .word_idx(i1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input ent_t e);
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Whole transfer as a list of per-cycle line states: frames of start/data/stop bits, then done.
  task automatic build(input int ch, input int cpb, input logic [3:0] f, input logic [WW-1:0] w);
    ent_t e;
    logic b;
    for (int k = 0; k <= int'(f); k++) begin
      for (int p = 0; p < LEN + 2; p++) begin
        if (p == 0) b = 1'b0;
        else if (p == LEN + 1) b = 1'b1;
        else b = w[k*LEN + p - 1];
        e.ser = b; e.busy = 1'b1; e.done = 1'b0; e.idx = 4'(k);
        repeat (cpb) push(ch, e);
      end
    end
    e.ser = 1'b1; e.busy = 1'b0; e.done = 1'b1; e.idx = f;
    push(ch, e);
  endtask

  task automatic step(input int ch, input logic st, input logic [3:0] f, input logic [WW-1:0] w, input int cpb);
    ent_t cur;
    logic prev_idle;
    cur = (ch == 0) ? e0 : e1;
    prev_idle = !cur.busy && !cur.done;
    if (RST) begin
      if (ch == 0) q0.delete(); else q1.delete();
      cur = 7'b100_0000;
    end else begin
      if (st && prev_idle) build(ch, cpb, f, w);
      if (ch == 0 && q0.size() > 0) cur = q0.pop_front();
      else if (ch == 1 && q1.size() > 0) cur = q1.pop_front();
      else begin cur.ser = 1'b1; cur.busy = 1'b0; cur.done = 1'b0; end
    end
    if (ch == 0) e0 = cur; else e1 = cur;
  endtask

  always @(posedge clk) begin
    step(0, start0, feat0, weights0, 4);
    step(1, start1, feat1, weights1, 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_dut0", {57'd0, s0, b0, d0, i0}, {57'd0, e0});
      chk("cycle_dut1", {57'd0, s1, b1, d1, i1}, {57'd0, e1});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch);
    if (ch == 0) start0 = 1'b1; else start1 = 1'b1;
    tick;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Record n cycles of one instance (cycle 1 = first cycle after the start edge) with optional injections.
  task automatic cap(input int ch, input int n, input int inj_a, input int inj_b, input int chg, input int rst_c);
    for (int c = 1; c <= n; c++) begin
      ser_log[c]  = (ch == 0) ? s0 : s1;
      busy_log[c] = (ch == 0) ? b0 : b1;
      done_log[c] = (ch == 0) ? d0 : d1;
      idx_log[c]  = (ch == 0) ? i0 : i1;
      if (ch == 0) start0 = (c == inj_a) || (c == inj_b);
      else start1 = (c == inj_a) || (c == inj_b);
      if (c == chg) begin
        weights0 = ~weights0;
        feat0 = 4'd9;
      end
      RST = (c == rst_c);
      tick;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    RST = 1'b0;
  endtask

  function automatic int cnt_busy(input int n);
    int s = 0;
    for (int c = 1; c <= n; c++) if (busy_log[c] === 1'b1) s++;
    return s;
  endfunction

  function automatic int cnt_done(input int n);
    int s = 0;
    for (int c = 1; c <= n; c++) if (done_log[c] === 1'b1) s++;
    return s;
  endfunction

  function automatic int first_done(input int n);
    for (int c = 1; c <= n; c++) if (done_log[c] === 1'b1) return c;
    return -1;
  endfunction

  function automatic logic [15:0] dec(input int w, input int cpb);
    logic [15:0] v;
    int base = 1 + w * (LEN + 2) * cpb;
    for (int i = 0; i < LEN; i++) v[i] = ser_log[base + (1 + i) * cpb];
    return v;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WW-1:0] w_save;
    int expb;

    RST = 1'b1;
    tick;
    chk_en = 1'b1;

    // Reset held with start toggling
    for (int c = 0; c < 3; c++) begin
      start0 = c[0];
      start1 = ~c[0];
      tick;
      chk("rst_ser", {63'd0, s0}, 64'd1);
      chk("rst_busy", {63'd0, b0}, 64'd0);
      chk("rst_done", {63'd0, d0}, 64'd0);
      chk("rst_idx", {60'd0, i0}, 64'd0);
    end
    RST = 1'b0; start0 = 1'b0; start1 = 1'b0;
    tick;

    // Single word 0xA5C3
    feat0 = 4'd0;
    weights0 = {WW{1'b0}};
    weights0[15:0] = 16'hA5C3;
    pulse(0);
    cap(0, 80, -1, -1, -1, -1);
    for (int c = 1; c <= 4; c++) chk("single_start_bit", {63'd0, ser_log[c]}, 64'd0);
    chk("single_word", {48'd0, dec(0, 4)}, 64'hA5C3);
    for (int c = 69; c <= 72; c++) chk("single_stop_bit", {63'd0, ser_log[c]}, 64'd1);
    chk("single_done_cycle", 64'(first_done(80)), 64'd73);
    chk("single_done_count", 64'(cnt_done(80)), 64'd1);
    chk("single_busy_cycles", 64'(cnt_busy(80)), 64'd72);

    // Full vector, 16 words
    feat0 = 4'd15;
    for (int k = 0; k < 16; k++) weights0[k*16 +: 16] = 16'h1000 + 16'(k);
    pulse(0);
    cap(0, 1160, -1, -1, -1, -1);
    chk("full_busy_cycles", 64'(cnt_busy(1160)), 64'd1152);
    chk("full_done_count", 64'(cnt_done(1160)), 64'd1);
    chk("full_done_cycle", 64'(first_done(1160)), 64'd1153);
    for (int k = 0; k < 16; k++) begin
      chk("full_word", {48'd0, dec(k, 4)}, 64'h1000 + 64'(k));
      chk("full_word_idx", {60'd0, idx_log[1 + k*72]}, 64'(k));
    end

    // Ignored starts (mid-transfer and in FINISH) and post-start input changes
    feat0 = 4'd1;
    for (int k = 0; k < 8; k++) weights0[k*32 +: 32] = $urandom;
    w_save = weights0;
    pulse(0);
    cap(0, 150, 40, 145, 3, -1);
    chk("ign_busy_cycles", 64'(cnt_busy(150)), 64'd144);
    chk("ign_done_count", 64'(cnt_done(150)), 64'd1);
    chk("ign_word0", {48'd0, dec(0, 4)}, {48'd0, w_save[15:0]});
    chk("ign_word1", {48'd0, dec(1, 4)}, {48'd0, w_save[31:16]});

    // Reset in the middle of a feat=2 transfer, then a clean transfer
    feat0 = 4'd2;
    for (int k = 0; k < 8; k++) weights0[k*32 +: 32] = $urandom;
    pulse(0);
    cap(0, 60, -1, -1, -1, 29);
    chk("rst_mid_busy_before", {63'd0, busy_log[29]}, 64'd1);
    chk("rst_mid_busy_after", {63'd0, busy_log[30]}, 64'd0);
    chk("rst_mid_ser_after", {63'd0, ser_log[30]}, 64'd1);
    chk("rst_mid_no_done", 64'(cnt_done(60)), 64'd0);
    for (int k = 0; k < 8; k++) weights0[k*32 +: 32] = $urandom;
    w_save = weights0;
    pulse(0);
    cap(0, 220, -1, -1, -1, -1);
    chk("after_rst_busy_cycles", 64'(cnt_busy(220)), 64'd216);
    chk("after_rst_done_cycle", 64'(first_done(220)), 64'd217);
    for (int k = 0; k < 3; k++) chk("after_rst_word", {48'd0, dec(k, 4)}, {48'd0, w_save[k*16 +: 16]});

    // One clock per bit, words 0xFFFF then 0x0000
    feat1 = 4'd1;
    weights1 = {WW{1'b0}};
    weights1[15:0] = 16'hFFFF;
    pulse(1);
    cap(1, 40, -1, -1, -1, -1);
    for (int c = 1; c <= 36; c++) begin
      if (c == 1 || c == 19) expb = 0;
      else if (c <= 18) expb = 1;
      else if (c == 36) expb = 1;
      else expb = 0;
      chk("cpb1_bit", {63'd0, ser_log[c]}, 64'(expb));
    end
    chk("cpb1_busy_cycles", 64'(cnt_busy(40)), 64'd36);
    chk("cpb1_done_cycle", 64'(first_done(40)), 64'd37);

    // Random traffic on both instances, checked cycle by cycle against the model
    for (int c = 0; c < 1500; c++) begin
      start0 = ($urandom_range(0, 39) == 0);
      start1 = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) begin
        feat0 = 4'($urandom_range(0, 15));
        feat1 = 4'($urandom_range(0, 15));
        for (int k = 0; k < 8; k++) begin
          weights0[k*32 +: 32] = $urandom;
          weights1[k*32 +: 32] = $urandom;
        end
      end
      RST = ($urandom_range(0, 399) == 0);
      tick;
    end
    start0 = 1'b0; start1 = 1'b0; RST = 1'b0;
    repeat (1200) tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
